// File: rtl/mc_mem_responder.sv
// Instruction/data memory responder for the multicycle RISC-V core.
// Synchronous-read word RAMs with registered outputs, range/alignment checking and access counters.
module mc_mem_responder #(
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter int unsigned TEXT_WORDS = 1024,
  parameter int unsigned DATA_WORDS = 1024,
  parameter string       TEXT_INIT  = "",
  parameter string       DATA_INIT  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] instruction,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  output logic        err_addr,
  output logic        err_align,
  output logic        err_proto,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned TAW      = $clog2(TEXT_WORDS);
  localparam int unsigned DAW      = $clog2(DATA_WORDS);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [31:0] text_mem [TEXT_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  logic [31:0]    text_off;
  logic [31:0]    data_off;
  logic [TAW-1:0] text_idx;
  logic [DAW-1:0] data_idx;
  logic           text_in;
  logic           data_in;
  logic           pc_mis;
  logic           d_mis;
  logic           d_active;
  logic           ld_req;
  logic           ld_ok;
  logic           st_ok;

  // Address decode; wrap-around of the unsigned subtraction is caught by the base compare.
  always_comb begin
    text_off = PC - TEXT_BASE;
    data_off = dAddress - DATA_BASE;
    text_idx = text_off[TAW+1:2];
    data_idx = data_off[DAW+1:2];
    text_in  = (PC >= TEXT_BASE) && ((text_off >> 2) < 32'(TEXT_WORDS));
    data_in  = (dAddress >= DATA_BASE) && ((data_off >> 2) < 32'(DATA_WORDS));
    pc_mis   = PC[1:0] != 2'b00;
    d_mis    = dAddress[1:0] != 2'b00;
    d_active = MemRead || MemWrite;
    ld_req   = MemRead && !MemWrite;
    ld_ok    = ld_req && data_in && !d_mis;
    st_ok    = MemWrite && data_in && !d_mis;
  end

  // Data RAM write port; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && st_ok) begin
      data_mem[data_idx] <= dWriteData;
    end
  end

  // Registered read data, sticky error flags and saturating access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSN;
      dReadData   <= 32'h0;
      err_addr    <= 1'b0;
      err_align   <= 1'b0;
      err_proto   <= 1'b0;
      rd_count    <= 16'h0;
      wr_count    <= 16'h0;
    end else begin
      instruction <= text_in ? text_mem[text_idx] : NOP_INSN;
      if (ld_ok) begin
        dReadData <= data_mem[data_idx];
      end else if (ld_req) begin
        dReadData <= 32'h0;
      end
      err_addr  <= err_addr  || !text_in || (d_active && !data_in);
      err_align <= err_align || pc_mis   || (d_active && d_mis);
      err_proto <= err_proto || (MemRead && MemWrite);
      if (ld_ok && rd_count != CNT_MAX) begin
        rd_count <= rd_count + 16'd1;
      end
      if (st_ok && wr_count != CNT_MAX) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder: directed vectors push expected outputs,
// a monitor compares them one edge later; includes a scripted lw/sw/beq program.
module tb_mc_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dReadData;
  logic        err_addr;
  logic        err_align;
  logic        err_proto;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  mc_mem_responder dut (
    .clk(clk), .rst(rst), .PC(PC), .instruction(instruction),
    .dAddress(dAddress), .dWriteData(dWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .dReadData(dReadData), .err_addr(err_addr), .err_align(err_align), .err_proto(err_proto),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic [31:0] rdat;
    logic [2:0]  err;
    logic [15:0] rc;
    logic [15:0] wc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_rdat;
  logic [15:0] m_rc;
  logic [15:0] m_wc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else passed++;
  endtask

  // Monitor: outputs settle just after each rising edge; compare against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".instruction"}, instruction, e.ins);
      chk({e.nm, ".dReadData"}, dReadData, e.rdat);
      chk({e.nm, ".err"}, {29'h0, err_addr, err_align, err_proto}, {29'h0, e.err});
      chk({e.nm, ".rd_count"}, {16'h0, rd_count}, {16'h0, e.rc});
      chk({e.nm, ".wr_count"}, {16'h0, wr_count}, {16'h0, e.wc});
    end
  end

  task automatic step(input string nm, input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] wd, input logic rd, input logic wr,
                      input logic [31:0] e_ins, input logic [31:0] e_rdat,
                      input logic [2:0] e_err, input logic [15:0] e_rc, input logic [15:0] e_wc);
    @(negedge clk);
    PC = pc; dAddress = addr; dWriteData = wd; MemRead = rd; MemWrite = wr;
    sb.push_back('{nm, e_ins, e_rdat, e_err, e_rc, e_wc});
  endtask

  // One instruction through IF/ID/EX/MEM/WB with PC held stable; strobes only in MEM.
  task automatic run_instr(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                           input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] ld_val);
    logic [31:0] r_after;
    r_after = (rd && !wr) ? ld_val : m_rdat;
    step({nm, ".if"}, pc, 32'h0, 32'h0, 1'b0, 1'b0, ins, m_rdat, 3'b111, m_rc, m_wc);
    step({nm, ".id"}, pc, 32'h0, 32'h0, 1'b0, 1'b0, ins, m_rdat, 3'b111, m_rc, m_wc);
    step({nm, ".ex"}, pc, 32'h0, 32'h0, 1'b0, 1'b0, ins, m_rdat, 3'b111, m_rc, m_wc);
    if (rd && !wr) m_rc = m_rc + 16'd1;
    if (wr) m_wc = m_wc + 16'd1;
    step({nm, ".mem"}, pc, addr, wd, rd, wr, ins, r_after, 3'b111, m_rc, m_wc);
    m_rdat = r_after;
    step({nm, ".wb"}, pc, 32'h0, 32'h0, 1'b0, 1'b0, ins, m_rdat, 3'b111, m_rc, m_wc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x5;
    logic [31:0] x7;
    logic [31:0] pc;
    dut.text_mem[0]  = 32'h0050_0093;  // addi x1,x0,5
    dut.text_mem[1]  = 32'h00A0_0113;  // addi x2,x0,10
    dut.text_mem[16] = 32'h0083_2283;  // lw  x5,8(x6)
    dut.text_mem[17] = 32'h0053_2623;  // sw  x5,12(x6)
    dut.text_mem[18] = 32'h00C3_2383;  // lw  x7,12(x6)
    dut.text_mem[19] = 32'h0072_8463;  // beq x5,x7,+8
    dut.text_mem[20] = 32'h0000_0073;  // ecall, skipped by the taken branch
    dut.text_mem[21] = 32'h0053_2823;  // sw  x5,16(x6)

    rst = 1'b0; PC = 32'h0040_0000; dAddress = 32'h0; dWriteData = 32'h0;
    MemRead = 1'b0; MemWrite = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("reset.instruction", instruction, NOP);
    chk("reset.dReadData", dReadData, 32'h0);
    chk("reset.err", {29'h0, err_addr, err_align, err_proto}, 32'h0);
    chk("reset.rd_count", {16'h0, rd_count}, 32'h0);
    chk("reset.wr_count", {16'h0, wr_count}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // fetch
    step("fetch0", 32'h0040_0000, 32'h0, 32'h0, 0, 0, 32'h0050_0093, 32'h0, 3'b000, 16'd0, 16'd0);
    step("fetch1", 32'h0040_0004, 32'h0, 32'h0, 0, 0, 32'h00A0_0113, 32'h0, 3'b000, 16'd0, 16'd0);
    // store then load, hold
    step("st8", 32'h0040_0000, 32'h1001_0008, 32'hDEAD_BEEF, 0, 1, 32'h0050_0093, 32'h0, 3'b000, 16'd0, 16'd1);
    step("st0", 32'h0040_0000, 32'h1001_0000, 32'hA5A5_A5A5, 0, 1, 32'h0050_0093, 32'h0, 3'b000, 16'd0, 16'd2);
    step("ld8", 32'h0040_0000, 32'h1001_0008, 32'h0, 1, 0, 32'h0050_0093, 32'hDEAD_BEEF, 3'b000, 16'd1, 16'd2);
    step("hold", 32'h0040_0000, 32'h0, 32'h0, 0, 0, 32'h0050_0093, 32'hDEAD_BEEF, 3'b000, 16'd1, 16'd2);
    // range and alignment errors
    step("ld_oor", 32'h0040_0000, 32'h1001_1000, 32'h0, 1, 0, 32'h0050_0093, 32'h0, 3'b100, 16'd1, 16'd2);
    step("st_mis", 32'h0040_0000, 32'h1001_0002, 32'h1234_5678, 0, 1, 32'h0050_0093, 32'h0, 3'b110, 16'd1, 16'd2);
    step("ld0", 32'h0040_0000, 32'h1001_0000, 32'h0, 1, 0, 32'h0050_0093, 32'hA5A5_A5A5, 3'b110, 16'd2, 16'd2);
    step("ld_mis", 32'h0040_0000, 32'h1001_0005, 32'h0, 1, 0, 32'h0050_0093, 32'h0, 3'b110, 16'd2, 16'd2);
    step("ld0b", 32'h0040_0000, 32'h1001_0000, 32'h0, 1, 0, 32'h0050_0093, 32'hA5A5_A5A5, 3'b110, 16'd3, 16'd2);
    step("ld_low", 32'h0040_0000, 32'h1000_FFFC, 32'h0, 1, 0, 32'h0050_0093, 32'h0, 3'b110, 16'd3, 16'd2);
    step("ld8b", 32'h0040_0000, 32'h1001_0008, 32'h0, 1, 0, 32'h0050_0093, 32'hDEAD_BEEF, 3'b110, 16'd4, 16'd2);
    // simultaneous read/write, then read-after-write
    step("both", 32'h0040_0000, 32'h1001_0010, 32'h1, 1, 1, 32'h0050_0093, 32'hDEAD_BEEF, 3'b111, 16'd4, 16'd3);
    step("ld16", 32'h0040_0000, 32'h1001_0010, 32'h0, 1, 0, 32'h0050_0093, 32'h1, 3'b111, 16'd5, 16'd3);
    step("st_oor", 32'h0040_0000, 32'h1001_1000, 32'hBAD, 0, 1, 32'h0050_0093, 32'h1, 3'b111, 16'd5, 16'd3);
    step("st20", 32'h0040_0000, 32'h1001_0014, 32'h777, 0, 1, 32'h0050_0093, 32'h1, 3'b111, 16'd5, 16'd4);
    // fetch boundaries
    step("pc_low", 32'h003F_FFFC, 32'h0, 32'h0, 0, 0, NOP, 32'h1, 3'b111, 16'd5, 16'd4);
    step("pc_high", 32'h0040_1000, 32'h0, 32'h0, 0, 0, NOP, 32'h1, 3'b111, 16'd5, 16'd4);
    step("pc_mis", 32'h0040_0006, 32'h0, 32'h0, 0, 0, 32'h00A0_0113, 32'h1, 3'b111, 16'd5, 16'd4);

    // program: x6 = DATA_BASE
    m_rdat = 32'h1; m_rc = 16'd5; m_wc = 16'd4;
    pc = 32'h0040_0040;
    run_instr("lw_x5", pc, 32'h0083_2283, 1, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF);
    x5 = 32'hDEAD_BEEF; pc = pc + 32'd4;
    run_instr("sw_x5", pc, 32'h0053_2623, 0, 1, 32'h1001_000C, x5, 32'h0);
    pc = pc + 32'd4;
    run_instr("lw_x7", pc, 32'h00C3_2383, 1, 0, 32'h1001_000C, 32'h0, x5);
    x7 = x5; pc = pc + 32'd4;
    run_instr("beq", pc, 32'h0072_8463, 0, 0, 32'h0, 32'h0, 32'h0);
    pc = (x5 == x7) ? pc + 32'd8 : pc + 32'd4;
    run_instr("sw_x5b", pc, 32'h0053_2823, 0, 1, 32'h1001_0010, x5, 32'h0);

    // asynchronous reset mid-cycle; store under reset must be dropped
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst.instruction", instruction, NOP);
    chk("midrst.dReadData", dReadData, 32'h0);
    chk("midrst.err", {29'h0, err_addr, err_align, err_proto}, 32'h0);
    chk("midrst.rd_count", {16'h0, rd_count}, 32'h0);
    chk("midrst.wr_count", {16'h0, wr_count}, 32'h0);
    @(negedge clk);
    dAddress = 32'h1001_0014; dWriteData = 32'h55; MemWrite = 1'b1;
    @(negedge clk);
    rst = 1'b0; MemWrite = 1'b0;

    step("post_ld20", 32'h0040_0040, 32'h1001_0014, 32'h0, 1, 0, 32'h0083_2283, 32'h777, 3'b000, 16'd1, 16'd0);
    step("post_ld16", 32'h0040_0040, 32'h1001_0010, 32'h0, 1, 0, 32'h0083_2283, 32'hDEAD_BEEF, 3'b000, 16'd2, 16'd0);
    step("post_idle", 32'h0040_0044, 32'h0, 32'h0, 0, 0, 32'h0053_2623, 32'hDEAD_BEEF, 3'b000, 16'd2, 16'd0);
    @(posedge clk); #2;

    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
